// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver state encodings, default bit timing and data width.
// Also used by the sender side so both ends agree on timing.
package uart_receiver_pkg;

  localparam int DATA_WIDTH           = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 87;  // 10 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEAN_UP  = 3'd4
  } rx_state_e;

  // Control state of the receiver; kept as one struct so checkers can bind to a single signal.
  typedef struct packed {
    rx_state_e  state;
    logic [2:0] bit_idx;
  } rx_fsm_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous rx pin.
// Presets to 1 so a reset looks like an idle line rather than a start bit.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, with mid-bit sampling and stop-bit check.
// Output handshake: valid is a one-cycle strobe with no ready; data_out is captured that cycle and held until the next good frame.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic                  rx_s;
  rx_fsm_t               fsm, fsm_next;
  logic [CNT_W-1:0]      clk_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  valid_next;
  logic                  ferr_next;
  logic                  bit_done;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  assign bit_done = (clk_cnt == LAST);

  always_comb begin
    fsm_next   = fsm;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (fsm.state)
      IDLE: begin
        fsm_next.bit_idx = 3'd0;
        if (!rx_s) fsm_next.state = START_BIT;
      end
      START_BIT: begin
        // Re-check the line half a bit in; a high line here was only a glitch.
        if (clk_cnt == HALF) fsm_next.state = rx_s ? IDLE : DATA_BITS;
      end
      DATA_BITS: begin
        if (bit_done) begin
          fsm_next.bit_idx = fsm.bit_idx + 3'd1;
          if (fsm.bit_idx == 3'd7) fsm_next.state = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (bit_done) begin
          fsm_next.state = CLEAN_UP;
          valid_next     = rx_s;
          ferr_next      = !rx_s;
        end
      end
      CLEAN_UP: begin
        // Wait for the line to go high so a held-low break cannot start a new frame.
        if (rx_s) fsm_next.state = IDLE;
      end
      default: fsm_next.state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= '{state: IDLE, bit_idx: 3'd0};
      clk_cnt   <= '0;
      shift     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      fsm       <= fsm_next;
      valid     <= valid_next;
      frame_err <= ferr_next;
      if (fsm_next.state != fsm.state || bit_done || fsm.state == IDLE) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
      if (fsm.state == DATA_BITS && bit_done) shift[fsm.bit_idx] <= rx_s;
      if (valid_next) data_out <= shift;
    end
  end

  assign busy = (fsm.state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a behavioural line driver, a frame-level expectation queue
// and a per-cycle compare process, plus literal checks on key results.
module tb_uart_receiver;

  localparam int CPB  = 8;
  localparam int SYNC = 2;
  localparam int LAT  = (CPB - 1) / 2 + 9 * CPB + SYNC + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc = 0;

  // Each entry is one expected pulse: bit 8 set = frame error, else valid with byte in [7:0].
  logic [8:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  int         valid_cyc[$];

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Clock and watchdog
  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Driver: one 8N1 frame, LSB first; expectation queued before the stop bit is sampled.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    exp_q.push_back({~stop, b});
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  // Scoreboard: compares every output on every cycle outside reset.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      exp_data = 8'h00;
      exp_q.delete();
    end else begin
      check("valid_ferr_exclusive", valid & frame_err, 1'b0);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b at cycle %0d, expected none",
                   valid, frame_err, cyc);
        end else begin
          e = exp_q.pop_front();
          if (valid) begin
            check("pulse_kind_valid", e[8], 1'b0);
            exp_data = e[7:0];
            valid_cyc.push_back(cyc);
          end else begin
            check("pulse_kind_ferr", e[8], 1'b1);
          end
        end
      end
      check("data_out", data_out, exp_data);
    end
  end

  initial begin
    logic [7:0] partial;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback byte with latency measurement
    valid_cyc.delete();
    send_frame(8'h7F, 1'b1);
    wait_idle(4, "loop_idle");
    check("loop_data", data_out, 8'h7F);
    check("loop_pulses", valid_cyc.size(), 1);
    if (valid_cyc.size() > 0) check_range("latency", valid_cyc[0] - start_cyc, LAT - 1, LAT + 1);
    repeat (5) @(negedge clk);

    // Start-bit glitch must be rejected
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("glitch_busy_seen", busy, 1'b1);
    wait_idle(5, "glitch_idle");
    repeat (10) @(negedge clk);
    check("glitch_data_kept", data_out, 8'h7F);

    // Framing error with the line held low afterwards
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_busy_held", busy, 1'b1);
    check("ferr_data_kept", data_out, 8'h7F);
    rx = 1'b1;
    wait_idle(5, "ferr_idle");
    repeat (5) @(negedge clk);

    // Back-to-back frames with no idle gap
    valid_cyc.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_idle(4, "b2b_idle");
    check("b2b_pulses", valid_cyc.size(), 2);
    if (valid_cyc.size() == 2) check_range("b2b_spacing", valid_cyc[1] - valid_cyc[0], 10 * CPB - 1, 10 * CPB + 1);
    check("b2b_data", data_out, 8'hFF);
    repeat (5) @(negedge clk);

    // Reset during data bit 3 of 8'h3C
    partial = 8'h3C;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = partial[i];
      repeat (CPB) @(negedge clk);
    end
    rx = partial[3];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_valid", valid, 1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'hA5, 1'b1);
    wait_idle(4, "after_rst_idle");
    check("after_rst_data", data_out, 8'hA5);
    repeat (5) @(negedge clk);

    check("pending_pulses", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
